// File: rtl/decoder_pkg.sv
// Shared 64b66b receive-path definitions: sync-header codes and block-sync FSM states.
// Used by the block-lock controller, the descrambler and the decoder.
package decoder_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    BS_TEST,
    BS_SLIP,
    BS_WAIT
  } bs_state_t;

  // 00 and 11 never occur on a correctly aligned 66-bit block.
  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_ctrl_if.sv
// 66-bit block stream (2-bit sync header + 64-bit payload) with a valid/ready handshake.
interface block_sync_ctrl_if;

  logic [1:0]  ttype;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (
    output ttype,
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  ttype,
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_reg_slice.sv
// Single-stage registered stream slice. A beat is captured only when load is high; the
// upstream ready is low while held data is stalled downstream, and during reset.
module axis_reg_slice #(
  parameter int unsigned W = 66
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !reset && (!valid_q || out_ready);
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // load is only raised for an accepted beat, so it never overwrites stalled data.
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= in_data;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/block_sync_ctrl.sv
// 64b66b block-lock controller: checks sync headers, runs the lock/slip FSM, and forwards
// blocks downstream only while lock is held.
module block_sync_ctrl
  import decoder_pkg::*;
#(
  parameter int unsigned SH_CNT_MAX = 64,
  parameter int unsigned INVLD_MAX  = 16,
  parameter int unsigned SLIP_WAIT  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  block_sync_ctrl_if.slave        s_axis,
  block_sync_ctrl_if.master       m_axis,
  output logic                    rx_slip,
  output logic                    block_lock,
  output logic [15:0]             slip_cnt
);

  localparam logic [6:0] ShCntMax = 7'(SH_CNT_MAX);
  localparam logic [4:0] InvldMax = 5'(INVLD_MAX);
  localparam logic [7:0] SlipWait = 8'(SLIP_WAIT);

  bs_state_t   state_q, state_d;
  logic [6:0]  sh_cnt_q, sh_cnt_d, sh_next;
  logic [4:0]  invld_cnt_q, invld_cnt_d, invld_next;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] slip_cnt_q, slip_cnt_d;
  logic        lock_q, lock_d;
  logic        go_slip;
  logic        s_ready;
  logic        accept;

  assign s_axis.tready = s_ready;
  assign accept        = s_axis.tvalid && s_ready;

  // Forwarding uses the lock value from before this beat's header update.
  axis_reg_slice #(
    .W (66)
  ) u_out_slice (
    .clk       (clk),
    .reset     (reset),
    .load      (accept && lock_q),
    .in_data   ({s_axis.ttype, s_axis.tdata}),
    .in_ready  (s_ready),
    .out_data  ({m_axis.ttype, m_axis.tdata}),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready)
  );

  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    invld_cnt_d = invld_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    lock_d      = lock_q;
    go_slip     = 1'b0;
    sh_next     = sh_cnt_q + 7'd1;
    invld_next  = invld_cnt_q + 5'd1;

    unique case (state_q)
      BS_TEST: begin
        if (accept) begin
          sh_cnt_d = sh_next;
          if (!sh_valid(s_axis.ttype)) begin
            if (!lock_q || (invld_next == InvldMax)) begin
              go_slip = 1'b1;
            end else begin
              invld_cnt_d = invld_next;
            end
          end
          // A bad header on the last beat of a window slips rather than closing the window.
          if (go_slip) begin
            state_d     = BS_SLIP;
            lock_d      = 1'b0;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else if (sh_next == ShCntMax) begin
            if (invld_cnt_d == '0) begin
              lock_d = 1'b1;
            end
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end
        end
      end

      BS_SLIP: begin
        lock_d      = 1'b0;
        sh_cnt_d    = '0;
        invld_cnt_d = '0;
        if (slip_cnt_q != '1) begin
          slip_cnt_d = slip_cnt_q + 16'd1;
        end
        // A beat taken during the slip cycle already counts toward the settle window.
        if (accept && (SlipWait <= 8'd1)) begin
          state_d    = BS_TEST;
          wait_cnt_d = '0;
        end else begin
          state_d    = BS_WAIT;
          wait_cnt_d = accept ? 8'd1 : 8'd0;
        end
      end

      BS_WAIT: begin
        if (accept) begin
          if ((wait_cnt_q + 8'd1) >= SlipWait) begin
            state_d    = BS_TEST;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = BS_TEST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BS_TEST;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      wait_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_cnt_q    <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      lock_q      <= lock_d;
    end
  end

  assign rx_slip    = (state_q == BS_SLIP);
  assign block_lock = lock_q;
  assign slip_cnt   = slip_cnt_q;

endmodule
